// File: rtl/xc_aessub_pkg.sv
// Shared types and constants for the sequential AES SubBytes unit.
// Byte lane positions, rotation amount and beat count helper.
package xc_aessub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LANE_B0 = 0;
  localparam int LANE_B1 = 1;
  localparam int LANE_B2 = 2;
  localparam int LANE_B3 = 3;

  localparam int ROT_BYTES = 1;

  function automatic int nbeats(input int nlanes);
    return 4 / nlanes;
  endfunction

endpackage

// File: rtl/xc_aessub_lane_pack.sv
// Byte gather from two operands and result packing with rotate.
// Purely combinational; reusable by a single-cycle variant.
module xc_aessub_lane_pack
  import xc_aessub_pkg::*;
(
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_b,
  input  logic [31:0] i_s,
  input  logic        i_rot,
  output logic [31:0] o_result
);

  localparam int RB = ROT_BYTES * 8;

  logic w_unused;
  assign w_unused = ^{i_rs1[31:24], i_rs1[15:8],
                      i_rs2[23:16], i_rs2[7:0]};

  assign o_b[LANE_B0*8 +: 8] = i_rs1[7:0];
  assign o_b[LANE_B1*8 +: 8] = i_rs2[15:8];
  assign o_b[LANE_B2*8 +: 8] = i_rs1[23:16];
  assign o_b[LANE_B3*8 +: 8] = i_rs2[31:24];

  assign o_result = i_rot ? {i_s[31-RB:0], i_s[31 -: RB]} : i_s;

endmodule

// File: rtl/xc_aessub_sbox.sv
// Single-byte AES S-box: GF(2^8) inverse plus affine map.
// Inverse direction only built when XC_AESSUB_DEC_EN is defined.
module xc_aessub_sbox (
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] t, r;
    t = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    return x ^ rl(x, 1) ^ rl(x, 2) ^ rl(x, 3) ^ rl(x, 4) ^ 8'h63;
  endfunction

`ifdef XC_AESSUB_DEC_EN
  function automatic logic [7:0] aff_inv(input logic [7:0] x);
    return rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05;
  endfunction

  assign out = inv ? ginv(aff_inv(in)) : aff_fwd(ginv(in));
`else
  logic w_unused;
  assign w_unused = inv;
  assign out = aff_fwd(ginv(in));
`endif

endmodule

// File: rtl/xc_aessub_seq.sv
// Sequential AES SubBytes/InvSubBytes using NLANES shared S-boxes.
// Define XC_AESSUB_DEC_EN to build the inverse direction.
module xc_aessub_seq
  import xc_aessub_pkg::*;
#(
  parameter int NLANES = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        dec,
  input  logic        rot,
  output logic        ready,
  output logic [31:0] result,
  output logic        err
);

  localparam int NB = nbeats(NLANES);
  localparam logic [1:0] LAST = 2'(NB - 1);

`ifdef XC_AESSUB_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  generate
    if (NLANES != 1 && NLANES != 2 && NLANES != 4) begin : g_bad
      $error("xc_aessub_seq: NLANES must be 1, 2 or 4");
    end
  endgenerate

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_buf;
  logic        r_dec;
  logic        r_rot;
  logic        r_ready;
  logic [31:0] r_result;
  logic        r_err;

  int          w_base;
  logic [31:0] w_gather;
  logic [31:0] w_nbuf;
  logic [31:0] w_pack;
  logic [7:0]  w_sin  [NLANES];
  logic [7:0]  w_sout [NLANES];

  assign w_base = (NB == 1) ? 0 : int'(r_cnt) * NLANES;

  generate
    for (genvar g = 0; g < NLANES; g++) begin : g_lane
      assign w_sin[g] = r_buf[(w_base + g)*8 +: 8];
      xc_aessub_sbox u_sbox (
        .in  (w_sin[g]),
        .inv (r_dec),
        .out (w_sout[g])
      );
    end
  endgenerate

  // Merge this beat's S-box outputs into the byte buffer
  always_comb begin
    w_nbuf = r_buf;
    for (int l = 0; l < NLANES; l++) begin
      w_nbuf[(w_base + l)*8 +: 8] = w_sout[l];
    end
  end

  xc_aessub_lane_pack u_pack (
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .o_b      (w_gather),
    .i_s      (w_nbuf),
    .i_rot    (r_rot),
    .o_result (w_pack)
  );

  // Control FSM with registered handshake and result
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state  <= IDLE;
      r_cnt    <= 2'd0;
      r_buf    <= 32'h0;
      r_dec    <= 1'b0;
      r_rot    <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (valid) begin
            if (dec && !DEC_EN) begin
              r_state  <= DONE;
              r_ready  <= 1'b1;
              r_result <= 32'h0;
              r_err    <= 1'b1;
            end else begin
              r_buf   <= w_gather;
              r_dec   <= dec;
              r_rot   <= rot;
              r_cnt   <= 2'd0;
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!valid) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
          end else begin
            r_buf <= w_nbuf;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == LAST) begin
              r_state  <= DONE;
              r_ready  <= 1'b1;
              r_result <= w_pack;
              r_err    <= 1'b0;
            end
          end
        end
        DONE: begin
          r_ready <= 1'b0;
          r_cnt   <= 2'd0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign result = r_result;
  assign err    = r_err;

endmodule

// File: tb/tb_xc_aessub_seq.sv
// Scoreboard bench for xc_aessub_seq at NLANES = 1, 2 and 4.
// Reference S-box is the published AES table.
module tb_xc_aessub_seq;

`ifdef XC_AESSUB_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam logic [0:2047] SBT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct {
    int          id;
    logic [31:0] r;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  vld;
  logic [31:0] rs1, rs2;
  logic        dec, rot;
  logic [2:0]  rdy, err;
  logic [31:0] res [3];

  logic [7:0]  sb  [256];
  logic [7:0]  isb [256];
  exp_t        sbq [$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  xc_aessub_seq #(.NLANES(1)) u_dut0 (
    .g_clk(clk), .g_resetn(rst_n), .valid(vld[0]),
    .rs1(rs1), .rs2(rs2), .dec(dec), .rot(rot),
    .ready(rdy[0]), .result(res[0]), .err(err[0])
  );

  xc_aessub_seq #(.NLANES(2)) u_dut1 (
    .g_clk(clk), .g_resetn(rst_n), .valid(vld[1]),
    .rs1(rs1), .rs2(rs2), .dec(dec), .rot(rot),
    .ready(rdy[1]), .result(res[1]), .err(err[1])
  );

  xc_aessub_seq #(.NLANES(4)) u_dut2 (
    .g_clk(clk), .g_resetn(rst_n), .valid(vld[2]),
    .rs1(rs1), .rs2(rs2), .dec(dec), .rot(rot),
    .ready(rdy[2]), .result(res[2]), .err(err[2])
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic int nl_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [32:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic d, input logic r);
    logic [7:0]  bb [4];
    logic [31:0] s;
    if (d && !DEC_EN) return {1'b1, 32'h0};
    bb[0] = a[7:0];
    bb[1] = b[15:8];
    bb[2] = a[23:16];
    bb[3] = b[31:24];
    for (int i = 0; i < 4; i++) s[i*8 +: 8] = d ? isb[bb[i]] : sb[bb[i]];
    if (r) s = {s[23:0], s[31:24]};
    return {1'b0, s};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy[k]) begin
        if (sbq.size() == 0) begin
          chk("spurious_rdy", {31'b0, rdy[k]}, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("mon_id", k, mon_e.id);
          chk("mon_res", res[k], mon_e.r);
          chk("mon_err", {31'b0, err[k]}, {31'b0, mon_e.e});
        end
      end
    end
  end

  // Call at a negedge with the target DUT idle; returns at a negedge
  task automatic run(input int k, input logic [31:0] a,
                     input logic [31:0] b, input logic d,
                     input logic r, input string tag);
    logic [32:0] m;
    int n;
    m = model(a, b, d, r);
    sbq.push_back('{k, m[31:0], m[32]});
    rs1 = a; rs2 = b; dec = d; rot = r;
    vld[k] = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    do begin
      if (!m[32]) begin
        rs1 = $urandom; rs2 = $urandom;
        {dec, rot} = 2'($urandom);
      end
      @(negedge clk);
      n++;
    end while (!rdy[k] && n < 20);
    if (!rdy[k]) chk({tag, "_timeout"}, {31'b0, rdy[k]}, 32'd1);
    else if (!m[32]) chk({tag, "_lat"}, n, 4 / nl_of(k) + 1);
    vld[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev, ie;
    logic [7:0]  bt [4];
    int cnt, p, n, t_prev, k;
    logic [32:0] m;

    vld = 3'b0; rs1 = 0; rs2 = 0; dec = 0; rot = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sb[i] = SBT[i*8 +: 8];
      isb[sb[i]] = 8'(i);
    end
    #2 rst_n = 1'b0;
    #2;
    for (int j = 0; j < 3; j++) begin
      chk("rst_ready", {31'b0, rdy[j]}, 32'd0);
      chk("rst_result", res[j], 32'h0);
      chk("rst_err", {31'b0, err[j]}, 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int j = 0; j < 3; j++) begin
      run(j, 32'h00FF0053, 32'h01000000, 1'b0, 1'b0, "fwd");
      chk("fwd_res", res[j], 32'h7C1663ED);
      run(j, 32'h00FF0053, 32'h01000000, 1'b0, 1'b1, "fwd_rot");
      chk("fwd_rot_res", res[j], 32'h1663ED7C);
    end

    ie = DEC_EN ? 32'h01FF0053 : 32'h0;
    run(0, 32'h001600ED, 32'h7C006300, 1'b1, 1'b0, "inv");
    chk("inv_res", res[0], ie);
    chk("inv_err", {31'b0, err[0]}, {31'b0, !DEC_EN});
    run(2, 32'h001600ED, 32'h7C006300, 1'b1, 1'b0, "inv4");
    chk("inv4_res", res[2], ie);

    prev = res[0];
    rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0; dec = 0; rot = 0;
    vld[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(rdy[0]);
    end
    chk("abort_rdy", cnt, 0);
    chk("abort_res", res[0], prev);
    run(0, 32'h0, 32'h0, 1'b0, 1'b0, "zero");
    chk("zero_res", res[0], 32'h63636363);

    rs1 = 32'hA5A5A5A5; rs2 = 32'h5A5A5A5A; dec = 0; rot = 1;
    vld[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ready", {31'b0, rdy[0]}, 32'd0);
    chk("mrst_result", res[0], 32'h0);
    chk("mrst_err", {31'b0, err[0]}, 32'd0);
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, "post_rst");

    m = model(32'hC0FFEE11, 32'h8BADF00D, 1'b0, 1'b1);
    repeat (3) sbq.push_back('{1, m[31:0], m[32]});
    rs1 = 32'hC0FFEE11; rs2 = 32'h8BADF00D; dec = 0; rot = 1;
    vld[1] = 1'b1;
    p = 0; n = 0; t_prev = 0;
    while (p < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (rdy[1]) begin
        if (p > 0) chk("b2b_gap", n - t_prev, 4);
        t_prev = n;
        p++;
      end
    end
    vld[1] = 1'b0;
    chk("b2b_pulses", p, 3);
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int v = 0; v < 256; v++) begin
        for (int l = 0; l < 4; l++) bt[l] = 8'(v + l);
        run(2, {8'($urandom), bt[2], 8'($urandom), bt[0]},
               {bt[3], 8'($urandom), bt[1], 8'($urandom)},
               d[0], 1'($urandom), "sweep");
      end
    end

    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(2, 0));
      run(k, $urandom, $urandom, 1'($urandom), 1'($urandom), "rnd");
    end

    repeat (4) @(negedge clk);
    chk("sbq_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
